// File: rtl/frame_pack.sv
// Packs RADIX-bit symbols MSB-first into TRACEBACK_DEPTH-bit frames, with a second
// frame buffer so assembly continues under output backpressure. Define PACK_FLUSH_EN for i_flush / o_frame_len.
module frame_pack #(
    parameter int RADIX           = 4,
    parameter int TRACEBACK_DEPTH = 60,
    localparam int N  = TRACEBACK_DEPTH / RADIX,
    localparam int CW = (N > 1) ? $clog2(N) : 1,
    localparam int LW = $clog2(N + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef PACK_FLUSH_EN
    input  logic                       i_flush,
    output logic [LW-1:0]              o_frame_len,
`endif
    input  logic [RADIX-1:0]           i_sym,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [TRACEBACK_DEPTH-1:0] o_frame,
    output logic                       o_frame_valid,
    input  logic                       i_frame_ready
);

    logic [TRACEBACK_DEPTH-1:0] asm_q, asm_d, asm_ins;
    logic [TRACEBACK_DEPTH-1:0] frame_q, frame_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       asm_full_q, asm_full_d;
    logic                       frame_valid_q, frame_valid_d;
    logic                       accept, out_free, close;
`ifdef PACK_FLUSH_EN
    logic [LW-1:0]              len_q, len_d;
    logic [LW-1:0]              asm_len_q, asm_len_d;
    logic [LW-1:0]              close_len;
`endif

    assign accept   = i_valid && !asm_full_q;
    assign out_free = !frame_valid_q || i_frame_ready;

`ifdef PACK_FLUSH_EN
    // A flush closes whatever is in asm, including a symbol landing this cycle.
    assign close     = (accept && (cnt_q == CW'(N - 1)))
                     || (i_flush && !asm_full_q && ((cnt_q != '0) || accept));
    assign close_len = LW'(cnt_q) + LW'(accept);
`else
    assign close     = accept && (cnt_q == CW'(N - 1));
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        asm_ins = asm_q;
        for (int k = 0; k < N; k++) begin
            if (accept && (cnt_q == CW'(k))) begin
                asm_ins[TRACEBACK_DEPTH-1-k*RADIX -: RADIX] = i_sym;
            end
        end
    end

    always_comb begin
        asm_d         = asm_q;
        cnt_d         = cnt_q;
        asm_full_d    = asm_full_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q && !i_frame_ready;
`ifdef PACK_FLUSH_EN
        len_d         = len_q;
        asm_len_d     = asm_len_q;
`endif
        if (asm_full_q && out_free) begin
            // asm is cleared whenever its frame leaves, so flushed frames get zero LSBs.
            frame_d       = asm_q;
            frame_valid_d = 1'b1;
            asm_full_d    = 1'b0;
            asm_d         = '0;
`ifdef PACK_FLUSH_EN
            len_d         = asm_len_q;
`endif
        end else if (close) begin
            cnt_d = '0;
            if (out_free) begin
                frame_d       = asm_ins;
                frame_valid_d = 1'b1;
                asm_d         = '0;
`ifdef PACK_FLUSH_EN
                len_d         = close_len;
`endif
            end else begin
                asm_d      = asm_ins;
                asm_full_d = 1'b1;
`ifdef PACK_FLUSH_EN
                asm_len_d  = close_len;
`endif
            end
        end else if (accept) begin
            asm_d = asm_ins;
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q         <= '0;
            cnt_q         <= '0;
            asm_full_q    <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
`ifdef PACK_FLUSH_EN
            len_q         <= '0;
            asm_len_q     <= '0;
`endif
        end else begin
            asm_q         <= asm_d;
            cnt_q         <= cnt_d;
            asm_full_q    <= asm_full_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
`ifdef PACK_FLUSH_EN
            len_q         <= len_d;
            asm_len_q     <= asm_len_d;
`endif
        end
    end

    assign o_ready       = !asm_full_q;
    assign o_frame       = frame_q;
    assign o_frame_valid = frame_valid_q;
`ifdef PACK_FLUSH_EN
    assign o_frame_len   = len_q;
`endif

endmodule

// File: tb/tb_frame_pack.sv
// Self-checking bench for frame_pack: directed cases plus randomized traffic against a
// queue-based model of pending frames. Flush cases run when PACK_FLUSH_EN is defined.
module tb_frame_pack;

    localparam int R  = 4;
    localparam int TD = 60;
    localparam int N  = TD / R;
    localparam int LW = $clog2(N + 1);
`ifdef PACK_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [R-1:0]  i_sym = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [TD-1:0] o_frame;
    logic          o_frame_valid;
    logic          i_frame_ready = 1'b0;
`ifdef PACK_FLUSH_EN
    logic          i_flush = 1'b0;
    logic [LW-1:0] o_frame_len;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: symbols of the frame being built, and closed frames not yet taken by the consumer.
    logic [R-1:0]  part_q[$];
    logic [TD-1:0] exp_frame_q[$];
    int            exp_len_q[$];

    frame_pack #(.RADIX(R), .TRACEBACK_DEPTH(TD)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef PACK_FLUSH_EN
        .i_flush       (i_flush),
        .o_frame_len   (o_frame_len),
`endif
        .i_sym         (i_sym),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic close_part();
        logic [TD-1:0] f;
        int            n;
        f = '0;
        n = part_q.size();
        for (int k = 0; k < n; k++) f = (f << R) | TD'(part_q[k]);
        f = f << ((N - n) * R);
        exp_frame_q.push_back(f);
        exp_len_q.push_back(n);
        part_q.delete();
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic step(input logic v, input logic [R-1:0] s, input logic fr, input logic fl);
        int   pend;
        logic exp_ready, exp_valid;
        i_valid       = v;
        i_sym         = s;
        i_frame_ready = fr;
`ifdef PACK_FLUSH_EN
        i_flush       = fl;
`endif
        @(negedge clk);
        pend      = exp_frame_q.size();
        exp_ready = (pend < 2);
        exp_valid = (pend >= 1);
        check("ready", 64'(o_ready), 64'(exp_ready));
        check("frame_valid", 64'(o_frame_valid), 64'(exp_valid));
        if (exp_valid && fr) begin
            check("frame", 64'(o_frame), 64'(exp_frame_q[0]));
`ifdef PACK_FLUSH_EN
            check("frame_len", 64'(o_frame_len), 64'(exp_len_q[0]));
`endif
            void'(exp_frame_q.pop_front());
            void'(exp_len_q.pop_front());
        end
        if (v && exp_ready) part_q.push_back(s);
        if (part_q.size() == N) close_part();
        else if (FLUSH_EN && fl && pend < 2 && part_q.size() > 0) close_part();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid       = 1'b0;
        i_frame_ready = 1'b0;
`ifdef PACK_FLUSH_EN
        i_flush       = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        check("rst_frame", 64'(o_frame), 64'd0);
        check("rst_valid", 64'(o_frame_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
`ifdef PACK_FLUSH_EN
        check("rst_len", 64'(o_frame_len), 64'd0);
`endif
        part_q.delete();
        exp_frame_q.delete();
        exp_len_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Symbols 0x1..0xF back to back, consumer always ready.
        for (int i = 1; i <= N; i++) step(1'b1, R'(i), 1'b1, 1'b0);
        check("t1_frame", 64'(o_frame), 64'(60'h123456789ABCDEF));
        check("t1_valid", 64'(o_frame_valid), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t1_one_cycle", 64'(o_frame_valid), 64'd0);

        // Two frames with the consumer stalled: one in the output, one held.
        for (int i = 0; i < 2 * N; i++) step(1'b1, R'($urandom), 1'b0, 1'b0);
        check("t2_ready_low", 64'(o_ready), 64'd0);
        check("t2_valid", 64'(o_frame_valid), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t2_ready_back", 64'(o_ready), 64'd1);
        check("t2_second_valid", 64'(o_frame_valid), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t2_drained", 64'(o_frame_valid), 64'd0);

        // Continuous stream with the consumer toggling every cycle.
        for (int i = 0; i < 300; i++) step(1'b1, R'($urandom), 1'(i % 2), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-frame, then a fresh frame of 0xA symbols.
        for (int i = 0; i < 7; i++) step(1'b1, R'($urandom), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, R'(4'hA), 1'b1, 1'b0);
        check("t4_frame", 64'(o_frame), 64'(60'hAAAAAAAAAAAAAAA));
        check("t4_valid", 64'(o_frame_valid), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef PACK_FLUSH_EN
        step(1'b1, R'(4'hC), 1'b1, 1'b0);
        step(1'b1, R'(4'hD), 1'b1, 1'b0);
        step(1'b1, R'(4'hE), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("t5_frame", 64'(o_frame), 64'(60'hCDE000000000000));
        check("t5_len", 64'(o_frame_len), 64'd3);
        step(1'b0, '0, 1'b1, 1'b1);
        check("t5_empty_flush", 64'(o_frame_valid), 64'd0);
        for (int i = 1; i <= 4; i++) step(1'b1, R'(i), 1'b1, 1'b0);
        step(1'b1, R'(5), 1'b1, 1'b1);
        check("t6_frame", 64'(o_frame), 64'(60'h123450000000000));
        check("t6_len", 64'(o_frame_len), 64'd5);
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        // Randomized traffic: bursty producer, bursty consumer, occasional flush.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), R'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("final_drained", 64'(o_frame_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
